// File: rtl/std_pipe_pkg.sv
// Shared encodings for the valid/ready pipeline primitives (skid buffer, pipe FIFO).
package std_pipe_pkg;
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] pipe_state_t;

  localparam pipe_state_t STATE_EMPTY = 2'b00;
  localparam pipe_state_t STATE_BUSY  = 2'b01;
  localparam pipe_state_t STATE_FULL  = 2'b10;
endpackage

// File: rtl/std_dffre_n.sv
// Width-parameterised flop with load enable and asynchronous active-low clear to zero.
// Latency 1 cycle; no flow control of its own.
module std_dffre_n #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/std_skid_buffer.sv
// Two-entry (main + skid) registered valid/ready stage; 1-cycle latency, full throughput.
// Back-pressure absorbed by the skid entry so s_ready is a pure register decode.
module std_skid_buffer
  import std_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  pipe_state_t           state_q;
  pipe_state_t           state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic                  main_en;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  skid_en;
  logic                  rdy_q;
  logic                  up_xfer;

  // rdy_q holds s_ready low through reset and rises on the first edge after release.
  std_dffre_n #(.WIDTH(1)) u_rdy (
    .clk(clk), .resetn(resetn), .en(1'b1), .d(1'b1), .q(rdy_q)
  );

  std_dffre_n #(.WIDTH(STATE_W)) u_state (
    .clk(clk), .resetn(resetn), .en(1'b1), .d(state_d), .q(state_q)
  );

  std_dffre_n #(.WIDTH(DATA_WIDTH)) u_main (
    .clk(clk), .resetn(resetn), .en(main_en), .d(main_d), .q(main_q)
  );

  std_dffre_n #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk(clk), .resetn(resetn), .en(skid_en), .d(skid_d), .q(skid_q)
  );

  assign m_valid = (state_q != STATE_EMPTY);
  assign s_ready = rdy_q && (state_q != STATE_FULL);
  assign m_data  = main_q;
  assign up_xfer = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = s_data;
    skid_en = 1'b0;
    skid_d  = s_data;
    if (flush) begin
      state_d = STATE_EMPTY;
      main_en = 1'b1;
      main_d  = '0;
      skid_en = 1'b1;
      skid_d  = '0;
    end else begin
      case (state_q)
        STATE_BUSY: begin
          if (up_xfer && m_ready) begin
            main_en = 1'b1;
          end else if (up_xfer) begin
            skid_en = 1'b1;
            state_d = STATE_FULL;
          end else if (m_ready) begin
            state_d = STATE_EMPTY;
          end
        end
        STATE_FULL: begin
          if (m_ready) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = STATE_BUSY;
          end
        end
        // EMPTY and the unused encoding both behave as empty
        default: begin
          if (up_xfer) begin
            main_en = 1'b1;
            state_d = STATE_BUSY;
          end else begin
            state_d = STATE_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_skid_buffer.sv
// Bench for std_skid_buffer: directed scenarios plus random stalls against a queue model.
module tb_std_skid_buffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: an ordered queue of at most two items plus an out-of-reset flag.
  logic [7:0] mq[$];
  bit         rdy_ok;

  always #5 clk = ~clk;

  std_skid_buffer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_s_ready();
    return rdy_ok && (mq.size() < 2);
  endfunction

  // Applies the transfer rules to the model using the values present at the edge.
  task automatic model_edge();
    bit sr;
    bit mv;
    if (!resetn) begin
      mq.delete();
      rdy_ok = 1'b0;
    end else begin
      sr = exp_s_ready();
      mv = (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (mv && m_ready) void'(mq.pop_front());
        if (s_valid && sr) mq.push_back(s_data);
      end
      rdy_ok = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("m_valid", m_valid, mq.size() > 0);
    check("s_ready", s_ready, exp_s_ready());
    if (mq.size() > 0) check("m_data", m_data, mq[0]);
  endtask

  task automatic step(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    resetn  = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    m_ready = 1'b0;
    rdy_ok  = 1'b0;

    // Reset held with traffic pending: nothing visible, not ready.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      check("rst_m_data", m_data, 8'h00);
    end
    resetn = 1'b1;
    #1;
    check("rel_s_ready_pre_edge", s_ready, 1'b0);
    check("rel_m_valid_pre_edge", m_valid, 1'b0);
    // First edge after release: s_ready was low, so AA must not be taken.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("rel_s_ready_post_edge", s_ready, 1'b1);
    check("rel_no_accept", m_valid, 1'b0);

    // Back-to-back streaming.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check("stream_data", m_data, i);
      check("stream_ready", s_ready, 1'b1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_drained", m_valid, 1'b0);

    // Back-pressure into the skid entry and release.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    check("bp_full_ready", s_ready, 1'b0);
    check("bp_hold_data", m_data, 8'h11);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp_hold_data2", m_data, 8'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_second_out", m_data, 8'h22);
    check("bp_ready_back", s_ready, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_empty", m_valid, 1'b0);

    // Flush while full with a fresh item offered on the same edge.
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    check("fl_pre_full", s_ready, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    check("fl_m_valid", m_valid, 1'b0);
    check("fl_s_ready", s_ready, 1'b1);
    check("fl_m_data_zero", m_data, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_no_leak", m_valid, 1'b0);

    // Asynchronous reset between edges while holding an item.
    step(1'b1, 8'h66, 1'b0, 1'b0);
    check("ar_busy", m_data, 8'h66);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_m_valid", m_valid, 1'b0);
    check("ar_m_data", m_data, 8'h00);
    check("ar_s_ready", s_ready, 1'b0);
    mq.delete();
    rdy_ok = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    resetn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic and stalls with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)),
           ($urandom_range(63, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
